// File: rtl/dec_print_formatter_if.sv
// -----------------------------------------------------------------------------
// dec_print_formatter_if
// Handshake bundle between a value source, the decimal print formatter and a
// character sink.
//
// Signals:
//   in_valid  - source offers a value
//   in_data   - unsigned value to print (WIDTH bits)
//   in_ready  - formatter can accept a value
//   out_valid - out_data holds a valid character
//   out_data  - ASCII character
//   out_ready - sink accepts the character
//   busy      - formatter is working on a value
//
// Modports:
//   master - environment side (drives value and sink ready)
//   slave  - formatter side
// -----------------------------------------------------------------------------
interface dec_print_formatter_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [7:0]       out_data;
   logic             out_ready;
   logic             busy;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/dec_print_formatter.sv
// -----------------------------------------------------------------------------
// dec_print_formatter
// Converts each accepted unsigned value into decimal ASCII without leading
// zeros (same rendering as %0d) and streams it one byte per handshake,
// terminated by a newline (0x0A).
//
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high reset
//   bus   - dec_print_formatter_if.slave (in_valid/in_data/in_ready,
//           out_valid/out_data/out_ready, busy)
//
// Parameters:
//   WIDTH  - input value width, 1..16
//   DIGITS - decimal digits held internally (5 covers WIDTH = 16)
//
// Optional feature (macro DEC_PRINT_FORMATTER_PREFIX_EN):
//   when defined, every number is preceded by the text "count=".
// -----------------------------------------------------------------------------
module dec_print_formatter #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 5
) (
   input logic                  clk,
   input logic                  reset,
   dec_print_formatter_if.slave bus
);

   localparam int BCD_W = DIGITS * 4;
   localparam int CNT_W = 5;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CONVERT = 3'd1,
      ST_EMIT    = 3'd2,
`ifdef DEC_PRINT_FORMATTER_PREFIX_EN
      ST_PREFIX  = 3'd4,
`endif
      ST_NEWLINE = 3'd3
   } state_t;

   state_t           state_r, state_s;
   logic [WIDTH-1:0] val_r, val_s;
   logic [BCD_W-1:0] bcd_r, bcd_s, bcd_shift_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [2:0]       idx_r, idx_s;
   logic             out_valid_r, out_valid_s;
   logic [7:0]       out_data_r, out_data_s;
   logic             fire_s;
   logic             last_shift_s;

   // One double-dabble iteration: add 3 to every nibble >= 5, then shift in
   // the next value bit.
   function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] bcd,
                                                    input logic             bit_in);
      logic [BCD_W-1:0] adj;
      adj = bcd;
      for (int i = 32'sd0; i < DIGITS; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) begin
            adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
         end else begin
            adj[i*4 +: 4] = bcd[i*4 +: 4];
         end
      end
      return (adj << 1) | {{(BCD_W-1){1'b0}}, bit_in};
   endfunction

   // Index of the most significant nonzero nibble; 0 for a zero value so
   // that "0" is still printed.
   function automatic logic [2:0] msd_index(input logic [BCD_W-1:0] bcd);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 32'sd0; i < DIGITS; i++) begin
         if (bcd[i*4 +: 4] != 4'd0) begin
            idx = i[2:0];
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   function automatic logic [3:0] nibble_at(input logic [BCD_W-1:0] bcd,
                                            input logic [2:0]       idx);
      logic [BCD_W-1:0] sh;
      sh = bcd >> {idx, 2'b00};
      return sh[3:0];
   endfunction

   function automatic logic [7:0] ascii_digit(input logic [3:0] nib);
      return 8'h30 + {4'h0, nib};
   endfunction

`ifdef DEC_PRINT_FORMATTER_PREFIX_EN
   // "count=" character ROM
   function automatic logic [7:0] prefix_char(input logic [CNT_W-1:0] pos);
      logic [7:0] ch;
      case (pos)
         5'd0:    ch = 8'h63;
         5'd1:    ch = 8'h6F;
         5'd2:    ch = 8'h75;
         5'd3:    ch = 8'h6E;
         5'd4:    ch = 8'h74;
         5'd5:    ch = 8'h3D;
         default: ch = 8'h00;
      endcase
      return ch;
   endfunction
`endif

   assign fire_s       = out_valid_r & bus.out_ready;
   assign last_shift_s = (cnt_r == CNT_W'(WIDTH - 1));
   assign bcd_shift_s  = dabble_step(bcd_r, val_r[WIDTH-1]);

   assign bus.in_ready  = (state_r == ST_IDLE);
   assign bus.busy      = (state_r != ST_IDLE);
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.in_valid) begin
               state_s = ST_CONVERT;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_CONVERT: begin
            if (last_shift_s) begin
`ifdef DEC_PRINT_FORMATTER_PREFIX_EN
               state_s = ST_PREFIX;
`else
               state_s = ST_EMIT;
`endif
            end else begin
               state_s = ST_CONVERT;
            end
         end
`ifdef DEC_PRINT_FORMATTER_PREFIX_EN
         ST_PREFIX: begin
            if (fire_s && (cnt_r == 5'd5)) begin
               state_s = ST_EMIT;
            end else begin
               state_s = ST_PREFIX;
            end
         end
`endif
         ST_EMIT: begin
            if (fire_s && (idx_r == 3'd0)) begin
               state_s = ST_NEWLINE;
            end else begin
               state_s = ST_EMIT;
            end
         end
         ST_NEWLINE: begin
            if (fire_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_NEWLINE;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Datapath and next output-register values. The output registers are
   // loaded one cycle after entering a character state (out_valid low), and
   // afterwards advance only on a handshake so a stalled byte stays stable.
   always_comb begin
      val_s       = val_r;
      bcd_s       = bcd_r;
      cnt_s       = cnt_r;
      idx_s       = idx_r;
      out_valid_s = out_valid_r;
      out_data_s  = out_data_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.in_valid) begin
               val_s = bus.in_data;
               bcd_s = {BCD_W{1'b0}};
               cnt_s = {CNT_W{1'b0}};
               idx_s = 3'd0;
            end else begin
               val_s = val_r;
            end
         end
         ST_CONVERT: begin
            bcd_s = bcd_shift_s;
            val_s = val_r << 1;
            if (last_shift_s) begin
               cnt_s = {CNT_W{1'b0}};
               idx_s = msd_index(bcd_shift_s);
            end else begin
               cnt_s = cnt_r + 5'd1;
            end
         end
`ifdef DEC_PRINT_FORMATTER_PREFIX_EN
         ST_PREFIX: begin
            if (!out_valid_r) begin
               out_valid_s = 1'b1;
               out_data_s  = prefix_char(cnt_r);
            end else if (fire_s) begin
               if (cnt_r == 5'd5) begin
                  // Hand over directly to the first digit, no bubble.
                  out_data_s = ascii_digit(nibble_at(bcd_r, idx_r));
               end else begin
                  cnt_s      = cnt_r + 5'd1;
                  out_data_s = prefix_char(cnt_r + 5'd1);
               end
            end else begin
               out_data_s = out_data_r;
            end
         end
`endif
         ST_EMIT: begin
            if (!out_valid_r) begin
               out_valid_s = 1'b1;
               out_data_s  = ascii_digit(nibble_at(bcd_r, idx_r));
            end else if (fire_s) begin
               if (idx_r == 3'd0) begin
                  out_data_s = 8'h0A;
               end else begin
                  idx_s      = idx_r - 3'd1;
                  out_data_s = ascii_digit(nibble_at(bcd_r, idx_r - 3'd1));
               end
            end else begin
               out_data_s = out_data_r;
            end
         end
         ST_NEWLINE: begin
            if (fire_s) begin
               out_valid_s = 1'b0;
               out_data_s  = 8'h00;
            end else begin
               out_data_s = out_data_r;
            end
         end
         default: begin
            out_valid_s = 1'b0;
            out_data_s  = 8'h00;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         val_r       <= {WIDTH{1'b0}};
         bcd_r       <= {BCD_W{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         idx_r       <= 3'd0;
         out_valid_r <= 1'b0;
         out_data_r  <= 8'h00;
      end else begin
         val_r       <= val_s;
         bcd_r       <= bcd_s;
         cnt_r       <= cnt_s;
         idx_r       <= idx_s;
         out_valid_r <= out_valid_s;
         out_data_r  <= out_data_s;
      end
   end

endmodule
